imem_loader: RTL and testbench

Program loader that writes a RISC-V program into the processor's instruction memory before execution starts. It receives a byte stream over a valid/ready interface and assembles little-endian 32-bit words, which it writes to sequential word-aligned byte addresses through the instruction memory write port. It holds the processor in reset until a complete program has been received and its checksum verified. It is the writer side of the instruction memory, whose read side is the PC-addressed fetch path.

---
 rtl/imem_loader_pkg.sv | 26 ++
 rtl/imem_loader_byte_packer.sv | 31 +++
 rtl/imem_loader.sv | 134 +++++++++++++
 tb/tb_imem_loader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// Holds the loader state encoding and the byte/word geometry.
package imem_loader_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned WORD_W     = WORD_BYTES * BYTE_W;
    localparam int unsigned LEN_W      = 16;
    localparam int unsigned CNT_W      = $clog2(WORD_BYTES);

    typedef enum logic [2:0] {
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_WRITE,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

    // States in which the loader consumes stream bytes
    function automatic logic accepts_bytes(input state_t s);
        return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian 4-byte shift register: the first byte of a word lands in bits [7:0].
// word_full_c flags the shift that completes a word; word_next_c is the word after that shift.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              shift_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word_next_c,
    output logic              word_full_c
);

    logic [WORD_W-1:0] word;
    logic [CNT_W-1:0]  byte_cnt;

    // New bytes enter at the top so after four shifts the first byte sits at the bottom
    assign word_next_c = {byte_in, word[WORD_W-1:BYTE_W]};
    assign word_full_c = shift_en && (byte_cnt == CNT_W'(WORD_BYTES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (shift_en) begin
            word     <= word_next_c;
            byte_cnt <= byte_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Program loader: parses a length-prefixed, XOR-checksummed byte stream and writes
// little-endian words to instruction memory, holding the CPU in reset until verified.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 256,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error
);

    localparam int unsigned IDX_W = $clog2(MAX_WORDS + 1);
    localparam int unsigned CMP_W = LEN_W + 1;

    state_t             state;
    state_t             state_next;
    logic [BYTE_W-1:0]  len_lo;
    logic [LEN_W-1:0]   len;
    logic [BYTE_W-1:0]  checksum;
    logic [IDX_W-1:0]   word_idx;

    logic               accept_c;
    logic [LEN_W-1:0]   n_c;
    logic               last_word_c;
    logic               shift_en_c;
    logic [WORD_W-1:0]  word_next_c;
    logic               word_full_c;

    assign accept_c    = byte_valid && byte_ready;
    assign n_c         = {byte_data, len_lo};
    assign last_word_c = (CMP_W'(word_idx) + CMP_W'(1)) == CMP_W'(len);
    assign shift_en_c  = accept_c && (state == ST_DATA);

    byte_packer u_packer (
        .clock       (clock),
        .reset       (reset),
        .shift_en    (shift_en_c),
        .byte_in     (byte_data),
        .word_next_c (word_next_c),
        .word_full_c (word_full_c)
    );

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_LEN0;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_LEN0: begin
                if (accept_c) state_next = ST_LEN1;
            end
            ST_LEN1: begin
                if (accept_c) begin
                    if (CMP_W'(n_c) > CMP_W'(MAX_WORDS)) begin
                        state_next = ST_ERROR;
                    end else if (n_c == '0) begin
                        state_next = ST_CHECK;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (word_full_c) state_next = ST_WRITE;
            end
            ST_WRITE: begin
                state_next = last_word_c ? ST_CHECK : ST_DATA;
            end
            ST_CHECK: begin
                if (accept_c) state_next = (byte_data == checksum) ? ST_DONE : ST_ERROR;
            end
            ST_DONE:  state_next = ST_DONE;
            ST_ERROR: state_next = ST_ERROR;
            default:  state_next = ST_ERROR;
        endcase
    end

    // Datapath: length capture, running checksum, word index
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            len_lo   <= '0;
            len      <= '0;
            checksum <= '0;
            word_idx <= '0;
        end else begin
            if (accept_c && (state == ST_LEN0)) len_lo <= byte_data;
            if (accept_c && (state == ST_LEN1)) len <= n_c;
            if (accept_c && (state != ST_CHECK)) checksum <= checksum ^ byte_data;
            if (state == ST_WRITE) word_idx <= word_idx + IDX_W'(1);
        end
    end

    // Registered outputs, derived from the state being entered
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            byte_ready <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            byte_ready <= accepts_bytes(state_next);
            mem_we     <= (state_next == ST_WRITE);
            cpu_hold   <= (state_next != ST_DONE);
            load_done  <= (state_next == ST_DONE);
            load_error <= (state_next == ST_ERROR);
            // Address and data only move on entry to WRITE and hold otherwise
            if ((state_next == ST_WRITE) && (state != ST_WRITE)) begin
                mem_addr  <= ADDR_W'({word_idx, 2'b00});
                mem_wdata <= word_next_c;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: a stream-level model predicts writes
// and the final verdict; a negedge monitor checks every write strobe against the queue.
module tb_imem_loader;

    localparam int unsigned MAXW = 256;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;

    wr_t         exp_q[$];
    logic [7:0]  stream[$];
    logic [31:0] words[$];
    int          total = 0;
    int          bad = 0;

    always #5 clock = ~clock;

    imem_loader #(.MAX_WORDS(MAXW), .ADDR_W(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Write monitor: pops one expected write per strobe
    initial begin
        wr_t  e;
        logic prev_we;
        prev_we = 1'b0;
        forever begin
            @(negedge clock);
            if (mem_we === 1'b1) begin
                check("we_one_cycle", 32'(prev_we), 32'd0);
                check("ready_low_in_write", 32'(byte_ready), 32'd0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write actual=%h:%h required=none", mem_addr, mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", mem_addr, e.addr);
                    check("write_data", mem_wdata, e.data);
                end
            end
            prev_we = mem_we;
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_byte_ready"}, 32'(byte_ready), 32'd1);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "_load_done"}, 32'(load_done), 32'd0);
        check({tag, "_load_error"}, 32'(load_error), 32'd0);
    endtask

    // Called just after a posedge; returns 1 ns after the edge that took the byte
    task automatic send_byte(input logic [7:0] b, output bit ok);
        byte_valid = 1'b1;
        byte_data  = b;
        ok = 1'b0;
        for (int c = 0; c < 64; c++) begin
            if (byte_ready) begin
                @(posedge clock);
                #1;
                ok = 1'b1;
                break;
            end
            @(posedge clock);
            #1;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout actual=not_accepted required=accepted byte=%h", b);
        end
    endtask

    task automatic gap(input bit gaps);
        int k;
        k = gaps ? int'($urandom_range(0, 3)) : 0;
        if (k > 0) begin
            byte_valid = 1'b0;
            repeat (k) begin
                @(posedge clock);
                #1;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    // Builds stream from length field and words[]; checksum is the XOR of all preceding bytes
    task automatic build(input logic [15:0] nfield, input bit bad_chk,
                         input bit force_chk, input logic [7:0] chk_val);
        logic [7:0] x;
        stream.delete();
        stream.push_back(nfield[7:0]);
        stream.push_back(nfield[15:8]);
        if (int'(nfield) <= int'(MAXW)) begin
            foreach (words[i]) begin
                for (int b = 0; b < 4; b++) stream.push_back(8'(words[i] >> (8 * b)));
            end
            x = 8'h00;
            foreach (stream[i]) x = x ^ stream[i];
            if (force_chk) x = chk_val;
            else if (bad_chk) x = x ^ 8'($urandom_range(1, 255));
            stream.push_back(x);
        end
    endtask

    task automatic outcome(input bit d, input bit e);
        check("load_done", 32'(load_done), 32'(d));
        check("load_error", 32'(load_error), 32'(e));
        check("cpu_hold", 32'(cpu_hold), 32'(!d));
        check("byte_ready_after", 32'(byte_ready), 32'(!(d || e)));
    endtask

    // Stream-level reference: predicts writes and verdict, then drives the stream
    task automatic run_stream(input bit gaps);
        int         n;
        bit         ok;
        logic [7:0] x;
        bit         good;
        wr_t        w;
        n = int'({stream[1], stream[0]});
        if (n > int'(MAXW)) begin
            for (int k = 0; k < 2; k++) begin
                gap(gaps);
                send_byte(stream[k], ok);
            end
            byte_valid = 1'b0;
            outcome(1'b0, 1'b1);
            byte_valid = 1'b1;
            byte_data  = 8'($urandom);
            repeat (6) begin
                @(posedge clock);
                #1;
                check("error_blocks_bytes", 32'(byte_ready), 32'd0);
            end
            byte_valid = 1'b0;
        end else begin
            for (int i = 0; i < n; i++) begin
                w.addr = 32'(i * 4);
                w.data = {stream[5 + 4 * i], stream[4 + 4 * i], stream[3 + 4 * i], stream[2 + 4 * i]};
                exp_q.push_back(w);
            end
            x = 8'h00;
            for (int k = 0; k < stream.size() - 1; k++) x = x ^ stream[k];
            good = (stream[stream.size() - 1] == x);
            foreach (stream[k]) begin
                gap(gaps);
                send_byte(stream[k], ok);
                if (!ok) break;
            end
            byte_valid = 1'b0;
            outcome(good, !good);
            check("pending_writes", 32'(exp_q.size()), 32'd0);
        end
        exp_q.delete();
    endtask

    initial begin
        bit ok;
        wr_t w;
        int n;
        #12;
        check_reset_vals("reset");
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_reset_vals("post_reset");

        // Two-word program, continuous valid, correct checksum
        words = '{32'h0000_0013, 32'h0010_0093};
        build(16'd2, 1'b0, 1'b0, 8'h00);
        run_stream(1'b0);

        // Same program with checksum byte 0x81
        do_reset();
        build(16'd2, 1'b0, 1'b1, 8'h81);
        run_stream(1'b0);

        // Empty program
        do_reset();
        words.delete();
        build(16'd0, 1'b0, 1'b0, 8'h00);
        run_stream(1'b0);

        // Length one past the limit
        do_reset();
        build(16'h0101, 1'b0, 1'b0, 8'h00);
        run_stream(1'b0);

        // Largest legal program, continuous valid
        do_reset();
        words.delete();
        repeat (MAXW) words.push_back($urandom);
        build(16'(MAXW), 1'b0, 1'b0, 8'h00);
        run_stream(1'b0);

        // Reset mid-stream, just as the first word's write strobe is up
        do_reset();
        words.delete();
        repeat (3) words.push_back($urandom);
        build(16'd3, 1'b0, 1'b0, 8'h00);
        w.addr = 32'd0;
        w.data = words[0];
        exp_q.push_back(w);
        for (int k = 0; k < 6; k++) send_byte(stream[k], ok);
        check("we_before_abort", 32'(mem_we), 32'd1);
        #6;
        reset = 1'b0;
        #1;
        check_reset_vals("async_reset");
        check("abort_pending", 32'(exp_q.size()), 32'd0);
        byte_valid = 1'b0;
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        words = '{$urandom};
        build(16'd1, 1'b0, 1'b0, 8'h00);
        run_stream(1'b1);

        // Randomized streams
        for (int t = 0; t < 30; t++) begin
            do_reset();
            words.delete();
            if ($urandom_range(0, 7) == 0) begin
                build(16'($urandom_range(MAXW + 1, 65535)), 1'b0, 1'b0, 8'h00);
            end else begin
                n = int'($urandom_range(0, 6));
                repeat (n) words.push_back($urandom);
                build(16'(n), ($urandom_range(0, 3) == 0), 1'b0, 8'h00);
            end
            run_stream(bit'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
